// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  localparam int unsigned INSTR_BYTES = 4;
  localparam logic [31:0] NOP_WORD    = 32'h0;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous instruction FIFO of fetch_entry_t with clear, push/pop and occupancy count.
// Pointers wrap naturally (DEPTH is a power of two); simultaneous push and pop keeps the count.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     clear,
  input  logic                     push,
  input  fetch_entry_t             push_data,
  input  logic                     pop,
  output fetch_entry_t             head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;

  // Storage is reset so the head reads as a NOP with PC 0 out of reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '{instr: NOP_WORD, pc: 32'h0};
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign count = cnt;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: credit-based BRAM reads at pc, latency pipe, FIFO towards decode.
// Optional macro FETCH_BYPASS_EN forwards a returning word straight to decode when the FIFO is empty.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned MEM_LATENCY = 2,
  parameter int unsigned ADDR_W      = 15
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [31:0]       pc,
  output logic              pcread,
  input  logic              flush,
  output logic              imem_en,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [31:0]       out_pc
);

  localparam int unsigned CNT_W      = $clog2(DEPTH) + 1;
  localparam int unsigned IFL_W      = $clog2(MEM_LATENCY + 1);
  localparam int unsigned SUM_W      = ((CNT_W > IFL_W) ? CNT_W : IFL_W) + 1;
  localparam int unsigned BYTE_SHIFT = $clog2(INSTR_BYTES);

  logic                              run;
  logic [MEM_LATENCY-1:0]            pipe_vld;
  logic [MEM_LATENCY-1:0][31:0]      pipe_pc;
  logic [MEM_LATENCY:0]              vld_shift;
  logic [MEM_LATENCY:0][31:0]        pc_shift;
  logic [IFL_W-1:0]                  inflight;
  logic [CNT_W-1:0]                  fifo_count;
  logic [SUM_W-1:0]                  used;
  logic [SUM_W-1:0]                  limit;
  fetch_entry_t                      fifo_head;
  fetch_entry_t                      ret_entry;
  logic                              fifo_valid;
  logic                              last_vld;
  logic                              bypass;
  logic                              pop;
  logic                              fifo_pop;
  logic                              fifo_push;
  logic                              issue;

  // Holds off issue until the first clock edge after reset release.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) run <= 1'b0;
    else       run <= 1'b1;
  end

  assign vld_shift = {pipe_vld, issue};
  assign pc_shift  = {pipe_pc, pc};

  // Latency pipe mirrors the BRAM read pipeline; flush kills every in-flight fetch.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pipe_vld <= '0;
      pipe_pc  <= '0;
    end else begin
      pipe_vld <= flush ? '0 : vld_shift[MEM_LATENCY-1:0];
      pipe_pc  <= pc_shift[MEM_LATENCY-1:0];
    end
  end

  assign last_vld  = pipe_vld[MEM_LATENCY-1];
  assign inflight  = IFL_W'($countones(pipe_vld));
  assign ret_entry = '{instr: imem_rdata, pc: pipe_pc[MEM_LATENCY-1]};
  assign fifo_valid = (fifo_count != '0);

  always_comb begin
    bypass    = 1'b0;
    out_valid = fifo_valid;
    out_instr = fifo_head.instr;
    out_pc    = fifo_head.pc;
`ifdef FETCH_BYPASS_EN
    bypass = !fifo_valid && last_vld && !flush;
    if (bypass) begin
      out_valid = 1'b1;
      out_instr = ret_entry.instr;
      out_pc    = ret_entry.pc;
    end
`endif
  end

  // Credit: every issued fetch owns a FIFO slot until decode pops it.
  always_comb begin
    pop       = out_valid && out_ready;
    fifo_pop  = fifo_valid && out_ready && !flush;
    fifo_push = last_vld && !flush && !(bypass && out_ready);
    used      = SUM_W'(fifo_count) + SUM_W'(inflight);
    limit     = SUM_W'(DEPTH) + SUM_W'(pop);
    issue     = run && !flush && (used < limit);
  end

  assign pcread    = issue;
  assign imem_en   = issue;
  assign imem_addr = pc[ADDR_W+BYTE_SHIFT-1:BYTE_SHIFT];

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .clear     (flush),
    .push      (fifo_push),
    .push_data (ret_entry),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: PC register and BRAM models, stream-order reference, directed and random tests.
module tb_fetch_unit;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned LAT   = 2;
  localparam int unsigned AW    = 15;
`ifdef FETCH_BYPASS_EN
  localparam int unsigned FIRST_LAT = LAT;
`else
  localparam int unsigned FIRST_LAT = LAT + 1;
`endif
  localparam int unsigned FV = 1 + FIRST_LAT;

  logic          clk;
  logic          rstn;
  logic [31:0]   pc;
  logic          pcread;
  logic          flush;
  logic [31:0]   flush_tgt;
  logic          imem_en;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_rdata;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_instr;
  logic [31:0]   out_pc;

  int total = 0;
  int bad   = 0;

  fetch_unit #(
    .DEPTH       (DEPTH),
    .MEM_LATENCY (LAT),
    .ADDR_W      (AW)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .pc         (pc),
    .pcread     (pcread),
    .flush      (flush),
    .imem_en    (imem_en),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_instr  (out_instr),
    .out_pc     (out_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input logic [AW-1:0] a);
    return 32'(a) * 32'd3;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Core PC register: redirect on flush, else advance on pcread.
  always @(posedge clk or negedge rstn) begin
    if (!rstn)       pc <= 32'h0;
    else if (flush)  pc <= flush_tgt;
    else if (pcread) pc <= pc + 32'd4;
  end

  // BRAM model: data for a word address appears LAT cycles after the read.
  logic [AW-1:0] ma [LAT];
  always @(posedge clk) begin
    ma[0] <= imem_addr;
    for (int i = 1; i < LAT; i++) ma[i] <= ma[i-1];
  end
  assign imem_rdata = word_of(ma[LAT-1]);

  // Reference: accepted words must follow the PC stream from the last reset/redirect, gap-free.
  logic [31:0] exp_pc;
  int accepts = 0;
  int pending = 0;
  always @(negedge clk) begin
    if (!rstn) begin
      exp_pc  = 32'h0;
      pending = 0;
    end else if (flush) begin
      exp_pc  = flush_tgt;
      pending = 0;
      check("flush_no_issue", 32'(pcread), 32'd0);
    end else begin
      check("en_eq_pcread", 32'(imem_en), 32'(pcread));
      if (out_valid && out_ready) begin
        check("order_pc", out_pc, exp_pc);
        check("order_instr", out_instr, word_of(exp_pc[AW+1:2]));
        exp_pc  = exp_pc + 32'd4;
        accepts++;
        pending--;
      end
      if (pcread) pending++;
      check("credit", 32'(pending <= int'(DEPTH)), 32'd1);
    end
  end

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn      = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #2 rstn = 1'b1;
  endtask

  typedef struct {
    logic          ready;
    logic          exp_pcread;
    logic          exp_valid;
    logic [31:0]   exp_pc;
    logic          chk_addr;
    logic [AW-1:0] exp_addr;
  } vec_t;

  vec_t tbl [10];

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : main
    int first;
    int a0;
    bit seen;
    rstn      = 1'b0;
    flush     = 1'b0;
    flush_tgt = 32'h0;
    out_ready = 1'b0;

    // Stall-from-reset: exactly DEPTH issues, then drain resumes at PC 16.
    tbl[0] = '{ready: 1'b0, exp_pcread: 1'b0, exp_valid: 1'b0,     exp_pc: 32'h0, chk_addr: 1'b0, exp_addr: AW'(0)};
    tbl[1] = '{ready: 1'b0, exp_pcread: 1'b1, exp_valid: (1 >= FV), exp_pc: 32'h0, chk_addr: 1'b1, exp_addr: AW'(0)};
    tbl[2] = '{ready: 1'b0, exp_pcread: 1'b1, exp_valid: (2 >= FV), exp_pc: 32'h0, chk_addr: 1'b1, exp_addr: AW'(1)};
    tbl[3] = '{ready: 1'b0, exp_pcread: 1'b1, exp_valid: (3 >= FV), exp_pc: 32'h0, chk_addr: 1'b1, exp_addr: AW'(2)};
    tbl[4] = '{ready: 1'b0, exp_pcread: 1'b1, exp_valid: (4 >= FV), exp_pc: 32'h0, chk_addr: 1'b1, exp_addr: AW'(3)};
    tbl[5] = '{ready: 1'b0, exp_pcread: 1'b0, exp_valid: 1'b1,     exp_pc: 32'h0, chk_addr: 1'b0, exp_addr: AW'(0)};
    tbl[6] = '{ready: 1'b0, exp_pcread: 1'b0, exp_valid: 1'b1,     exp_pc: 32'h0, chk_addr: 1'b0, exp_addr: AW'(0)};
    tbl[7] = '{ready: 1'b0, exp_pcread: 1'b0, exp_valid: 1'b1,     exp_pc: 32'h0, chk_addr: 1'b0, exp_addr: AW'(0)};
    tbl[8] = '{ready: 1'b1, exp_pcread: 1'b1, exp_valid: 1'b1,     exp_pc: 32'h0, chk_addr: 1'b1, exp_addr: AW'(4)};
    tbl[9] = '{ready: 1'b1, exp_pcread: 1'b1, exp_valid: 1'b1,     exp_pc: 32'h4, chk_addr: 1'b1, exp_addr: AW'(5)};

    // Test 1: free-running stream after reset.
    do_reset();
    #1;
    check("reset_valid", 32'(out_valid), 32'd0);
    check("reset_pc", out_pc, 32'h0);
    check("reset_instr", out_instr, 32'h0);
    out_ready = 1'b1;
    first = -1;
    for (int c = 0; c < 12; c++) begin
      if (c > 0) next_cyc();
      @(negedge clk);
      check("t1_pcread", 32'(pcread), (c == 0) ? 32'd0 : 32'd1);
      if (out_valid && first < 0) first = c;
    end
    check("t1_first_valid", 32'(first), 32'(FV));

    // Test 2: table-driven stall and release.
    do_reset();
    for (int c = 0; c < 10; c++) begin
      if (c > 0) next_cyc();
      out_ready = tbl[c].ready;
      @(negedge clk);
      check("t2_pcread", 32'(pcread), 32'(tbl[c].exp_pcread));
      check("t2_valid", 32'(out_valid), 32'(tbl[c].exp_valid));
      if (tbl[c].exp_valid) check("t2_out_pc", out_pc, tbl[c].exp_pc);
      if (tbl[c].chk_addr) check("t2_addr", 32'(imem_addr), 32'(tbl[c].exp_addr));
    end
    repeat (8) next_cyc();

    // Test 3: redirect mid-stream from 0x40 to 0x100.
    do_reset();
    out_ready = 1'b1;
    flush     = 1'b1;
    flush_tgt = 32'h40;
    next_cyc();
    flush = 1'b0;
    repeat (10) next_cyc();
    flush     = 1'b1;
    flush_tgt = 32'h100;
    @(negedge clk);
    check("t3_flush_en", 32'(imem_en), 32'd0);
    next_cyc();
    flush = 1'b0;
    seen  = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1'b1;
        check("t3_redirect_pc", out_pc, 32'h100);
      end else begin
        next_cyc();
      end
    end
    check("t3_seen", 32'(seen), 32'd1);
    repeat (6) next_cyc();

    // Test 4: flush while a word returns into a nearly full FIFO.
    do_reset();
    repeat (6) next_cyc();
    flush     = 1'b1;
    flush_tgt = 32'h200;
    out_ready = 1'b1;
    @(negedge clk);
    check("t4_valid_before", 32'(out_valid), 32'd1);
    next_cyc();
    flush = 1'b0;
    @(negedge clk);
    check("t4_valid_after", 32'(out_valid), 32'd0);
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      next_cyc();
      @(negedge clk);
      if (out_valid) begin
        seen = 1'b1;
        check("t4_redirect_pc", out_pc, 32'h200);
      end
    end
    check("t4_seen", 32'(seen), 32'd1);
    repeat (4) next_cyc();

    // Test 5: asynchronous reset between edges.
    @(posedge clk);
    #3 rstn = 1'b0;
    #1;
    check("t5_valid", 32'(out_valid), 32'd0);
    check("t5_pcread", 32'(pcread), 32'd0);
    check("t5_en", 32'(imem_en), 32'd0);
    check("t5_out_pc", out_pc, 32'h0);
    repeat (2) @(posedge clk);
    #2 rstn = 1'b1;
    first = -1;
    for (int c = 0; c < 10; c++) begin
      if (c > 0) next_cyc();
      @(negedge clk);
      if (c == 1) check("t5_restart_addr", 32'(imem_addr), 32'd0);
      if (out_valid && first < 0) begin
        first = c;
        check("t5_first_pc", out_pc, 32'h0);
      end
    end
    check("t5_first_valid", 32'(first), 32'(FV));

    // Test 6: random backpressure and redirects against the stream reference.
    for (int c = 0; c < 3000; c++) begin
      next_cyc();
      out_ready = 1'($urandom_range(0, 1));
      flush     = ($urandom_range(0, 39) == 0);
      if (flush) flush_tgt = 32'($urandom_range(0, 8191)) << 2;
    end
    next_cyc();
    flush     = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    a0 = accepts;
    repeat (20) next_cyc();
    @(negedge clk);
    check("t6_drain_rate", 32'((accepts - a0) >= 15), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage sitting between the core's PC register and the decode stage. It issues word reads to instruction BRAM at the current PC and drives `pcread` to advance the PC. Returned words are buffered with their PC in a small FIFO. Decode drains the FIFO through a valid/ready handshake. A redirect (branch/jump load of the PC) flushes all buffered and in-flight fetches.

Parameters:
- DEPTH, 4: instruction FIFO entries; power of two, ≥2.
- MEM_LATENCY, 2: cycles from `imem_en` high to valid `imem_rdata`; fixed, ≥1.
- ADDR_W, 15: instruction memory word-address width.

Ports:
- clk  input  1  clock, all state on posedge.
- rstn  input  1  asynchronous active-low reset.
- pc  input  32  current PC from the core's PC register.
- pcread  output  1  request PC += 4 next cycle; high exactly when a fetch issues.
- flush  input  1  high in the cycle the core loads a redirect PC (`pcenable` accepted).
- imem_en  output  1  memory read enable.
- imem_addr  output  ADDR_W  word address, = `pc[ADDR_W+1:2]`.
- imem_rdata  input  32  read data, valid MEM_LATENCY cycles after `imem_en`.
- out_valid  output  1  FIFO head valid.
- out_ready  input  1  decode accepts head.
- out_instr  output  32  head instruction word.
- out_pc  output  32  PC of head instruction.

Behaviour:
- Reset (async, `rstn` low):
  - FIFO empty; in-flight pipe cleared.
  - `out_valid`=0, `pcread`=0, `imem_en`=0, `out_instr`=0, `out_pc`=0.
  - Reset mid-fetch discards everything; first issue occurs in the first cycle after `rstn` deasserts.
- Issue rule:
  - issue = !flush && (fifo_count + inflight_count − pop) < DEPTH, where pop = `out_valid` && `out_ready`.
  - `imem_en` = `pcread` = issue (combinational from registered state plus `flush`/`out_ready`).
  - Issue is credit-based; the FIFO never overflows, so there is no drop path.
- In-flight tracking:
  - A MEM_LATENCY-deep shift register of {valid, pc}.
  - Stage 0 is loaded with {issue, pc} each cycle.
  - When the last stage is valid, {imem_rdata, pc} is pushed into the FIFO that cycle.
- Flush:
  - FIFO emptied (count=0); all in-flight valid bits cleared, including the entry completing in that cycle.
  - `pcread` and `imem_en` are 0.
  - The next cycle issues from the new PC if credit allows (it always does, since all state is empty).
  - A pop in the same cycle as `flush` is ignored; decode must also discard the word it accepted.
- Simultaneous push and pop:
  - Count unchanged.
  - Push into a full FIFO only occurs with a pop in the same cycle; this is guaranteed by credit.
- Pointers: log2(DEPTH) bits, wrap naturally; count is log2(DEPTH)+1 bits.
- Throughput:
  - Sustained 1 instr/cycle when `out_ready`=1.
  - First `out_valid` appears MEM_LATENCY+1 cycles after the first issue after reset or flush (registered FIFO output).

Optional Feature:
FETCH_BYPASS_EN
- Defined: when the FIFO is empty and a returning word arrives, `out_valid`/`out_instr`/`out_pc` are driven straight from the pipe's last stage. With `out_ready`=1 the word is consumed without being written to the FIFO. First-instruction latency drops to MEM_LATENCY. `flush` still suppresses the bypassed word (`out_valid`=0 that cycle).
- Undefined: all returns go through FIFO storage; latency as above.

Decomposition:
- Package `fetch_pkg`: `fetch_entry_t` struct {instr[31:0], pc[31:0]}, localparam INSTR_BYTES=4, NOP word constant 32'h0.
- One sub-module `fetch_fifo`: synchronous FIFO of `fetch_entry_t` with push/pop/clear/count, async active-low reset.
- Issue/credit logic and the latency pipe live in `fetch_unit`.

Test Plan:
1. Reset, then `out_ready`=1, memory words = address×3 → consecutive `out_pc` 0,4,8,12… with matching instr; `pcread` high every cycle after the first; first `out_valid` at cycle MEM_LATENCY+1.
2. `out_ready`=0 from start → exactly DEPTH (4) issues, then `pcread`=0; FIFO holds PCs 0,4,8,12; release `out_ready` → drained in order, issue resumes at PC 16.
3. Steady stream at PC 0x40, assert `flush` one cycle while `pc` jumps to 0x100 → no word with PC 0x44–0x50 ever reaches output; next `out_pc`=0x100.
4. `flush` in the same cycle a word returns and FIFO is full with `out_ready`=1 → FIFO count 0 next cycle, returning word dropped, no overflow.
5. Assert `rstn`=0 asynchronously mid-stream (between edges) → `out_valid`, `pcread`, `imem_en` go 0 immediately; after release, fetch restarts from the `pc` input (0).
6. With FETCH_BYPASS_EN, empty FIFO, `out_ready`=1 → first `out_valid` at cycle MEM_LATENCY after issue; random `out_ready` toggling preserves order and completeness versus the reference PC sequence.
